// File: rtl/sram_phase_sequencer.sv
// Runs the LOAD, M1 and M2 decoder phases in order over one shared SRAM port.
// The bus is handed to one client at a time, with a parked guard gap between owners.
module sram_phase_sequencer #(
    parameter int unsigned GUARD_CYCLES = 3,
    parameter logic [23:0] TIMEOUT      = 24'd16000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Go,
    input  logic [2:0]  Skip,
    output logic        LOAD_Start,
    output logic        M1_Start,
    output logic        M2_Start,
    input  logic        LOAD_Stop,
    input  logic        M1_Stop,
    input  logic        M2_Stop,
    input  logic [17:0] LOAD_address,
    input  logic [17:0] M1_address,
    input  logic [17:0] M2_address,
    input  logic [15:0] LOAD_write_data,
    input  logic [15:0] M1_write_data,
    input  logic [15:0] M2_write_data,
    input  logic        LOAD_we_n,
    input  logic        M1_we_n,
    input  logic        M2_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [1:0]  Phase,
    output logic [23:0] Cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_GUARD = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [1:0]  PH_NONE    = 2'd3;
    localparam logic [3:0]  GUARD_LAST = 4'(GUARD_CYCLES - 1);
    localparam logic [23:0] CNT_MAX    = 24'hFFFFFF;

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  nxt_s;
    logic [2:0]  skip_q, skip_d;
    logic [2:0]  start_q, start_d;
    logic [23:0] run_cnt_q, run_cnt_d;
    logic [23:0] cycle_count_q, cycle_count_d;
    logic [3:0]  guard_cnt_q, guard_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        stop_s;

    // Lowest phase index >= lo that is not skipped; PH_NONE when none remains.
    function automatic logic [1:0] first_enabled(input logic [2:0] skip, input logic [1:0] lo);
        logic [1:0] sel;
        sel = PH_NONE;
        for (int i = 2; i >= 0; i--) begin
            if ((i >= int'(lo)) && !skip[i]) begin
                sel = 2'(i);
            end
        end
        return sel;
    endfunction

    // Completion level of the current owner only; other clients' Stops are ignored.
    always_comb begin
        case (owner_q)
            2'd0:    stop_s = LOAD_Stop;
            2'd1:    stop_s = M1_Stop;
            2'd2:    stop_s = M2_Stop;
            default: stop_s = 1'b0;
        endcase
    end

    // Sequencer next-state, counters and registered-output decode.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        owner_d       = owner_q;
        skip_d        = skip_q;
        run_cnt_d     = run_cnt_q;
        guard_cnt_d   = guard_cnt_q;
        cycle_count_d = cycle_count_q;
        nxt_s         = PH_NONE;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Go) begin
                    skip_d = Skip;
                    nxt_s  = first_enabled(Skip, 2'd0);
                    if (nxt_s == PH_NONE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                        phase_d = nxt_s;
                        owner_d = nxt_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_START: begin
                run_cnt_d = 24'd0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + 24'd1;
                if (stop_s) begin
                    cycle_count_d = run_cnt_d;
                    guard_cnt_d   = 4'd0;
                    owner_d       = PH_NONE;
                    state_d       = S_GUARD;
                end else if (run_cnt_d >= TIMEOUT) begin
                    owner_d = PH_NONE;
                    state_d = S_ERROR;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    nxt_s = first_enabled(skip_q, phase_q + 2'd1);
                    if (nxt_s == PH_NONE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                        phase_d = nxt_s;
                        owner_d = nxt_s;
                    end
                end else begin
                    guard_cnt_d = guard_cnt_q + 4'd1;
                end
            end
            S_ERROR: begin
                owner_d = PH_NONE;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = PH_NONE;
            end
        endcase

        start_d = 3'b000;
        if (state_d == S_START) begin
            start_d = 3'b001 << phase_d;
        end else begin
            start_d = 3'b000;
        end
        busy_d  = (state_d == S_START) || (state_d == S_RUN) || (state_d == S_GUARD);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            phase_q       <= PH_NONE;
            owner_q       <= PH_NONE;
            skip_q        <= 3'b000;
            start_q       <= 3'b000;
            run_cnt_q     <= 24'd0;
            cycle_count_q <= 24'd0;
            guard_cnt_q   <= 4'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            owner_q       <= owner_d;
            skip_q        <= skip_d;
            start_q       <= start_d;
            run_cnt_q     <= run_cnt_d;
            cycle_count_q <= cycle_count_d;
            guard_cnt_q   <= guard_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    // Zero-latency bus mux from the registered owner; parked when nobody owns it.
    always_comb begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        case (owner_q)
            2'd0: begin
                SRAM_address    = LOAD_address;
                SRAM_write_data = LOAD_write_data;
                SRAM_we_n       = LOAD_we_n;
            end
            2'd1: begin
                SRAM_address    = M1_address;
                SRAM_write_data = M1_write_data;
                SRAM_we_n       = M1_we_n;
            end
            2'd2: begin
                SRAM_address    = M2_address;
                SRAM_write_data = M2_write_data;
                SRAM_we_n       = M2_we_n;
            end
            default: begin
                SRAM_address    = 18'd0;
                SRAM_write_data = 16'd0;
                SRAM_we_n       = 1'b1;
            end
        endcase
    end

    assign LOAD_Start  = start_q[0];
    assign M1_Start    = start_q[1];
    assign M2_Start    = start_q[2];
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Error       = error_q;
    assign Phase       = phase_q;
    assign Cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Self-checking bench for sram_phase_sequencer: expected behaviour comes from a
// schedule computed per sequence (start cycle, run length, guard gap per phase).
module tb_sram_phase_sequencer;

    localparam int G  = 3;
    localparam int TO = 100;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Go;
    logic [2:0]  Skip;
    logic        LOAD_Start, M1_Start, M2_Start;
    logic [2:0]  stop_v;
    logic [2:0]  we_v;
    logic [15:0] wd [3];
    logic [17:0] addr_c [3];
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        Busy, Done, Error;
    logic [1:0]  Phase;
    logic [23:0] Cycle_count;
    logic [2:0]  start_v;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [1:0]  exp_phase;
    logic [23:0] exp_cc;

    assign start_v = {M2_Start, M1_Start, LOAD_Start};

    always #5 Clock = ~Clock;

    sram_phase_sequencer #(.GUARD_CYCLES(G), .TIMEOUT(24'(TO))) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Go             (Go),
        .Skip           (Skip),
        .LOAD_Start     (LOAD_Start),
        .M1_Start       (M1_Start),
        .M2_Start       (M2_Start),
        .LOAD_Stop      (stop_v[0]),
        .M1_Stop        (stop_v[1]),
        .M2_Stop        (stop_v[2]),
        .LOAD_address   (addr_c[0]),
        .M1_address     (addr_c[1]),
        .M2_address     (addr_c[2]),
        .LOAD_write_data(wd[0]),
        .M1_write_data  (wd[1]),
        .M2_write_data  (wd[2]),
        .LOAD_we_n      (we_v[0]),
        .M1_we_n        (we_v[1]),
        .M2_we_n        (we_v[2]),
        .SRAM_address   (SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n      (SRAM_we_n),
        .Busy           (Busy),
        .Done           (Done),
        .Error          (Error),
        .Phase          (Phase),
        .Cycle_count    (Cycle_count)
    );

    task automatic tick();
        @(posedge Clock);
        cyc++;
        #1;
    endtask

    // Random client data each cycle; Stop forced where the schedule needs it.
    task automatic drive(input logic [2:0] force_m, input logic [2:0] force_v);
        for (int i = 0; i < 3; i++) begin
            wd[i]     = 16'($urandom);
            we_v[i]   = ($urandom_range(0, 3) == 0);
            stop_v[i] = force_m[i] ? force_v[i] : 1'($urandom_range(0, 1));
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_cycle(input logic [2:0] e_start, input logic [1:0] e_own,
                               input logic e_busy, input logic e_done, input logic e_err);
        logic [17:0] e_addr;
        logic [15:0] e_wd;
        logic        e_we;
        if (e_own == 2'd3) begin
            e_addr = 18'd0;
            e_wd   = 16'd0;
            e_we   = 1'b1;
        end else begin
            e_addr = addr_c[e_own];
            e_wd   = wd[e_own];
            e_we   = we_v[e_own];
        end
        chk("start",       32'(start_v),         32'(e_start));
        chk("sram_addr",   32'(SRAM_address),    32'(e_addr));
        chk("sram_wdata",  32'(SRAM_write_data), 32'(e_wd));
        chk("sram_we_n",   32'(SRAM_we_n),       32'(e_we));
        chk("busy",        32'(Busy),            32'(e_busy));
        chk("done",        32'(Done),            32'(e_done));
        chk("error",       32'(Error),           32'(e_err));
        chk("phase",       32'(Phase),           32'(exp_phase));
        chk("cycle_count", 32'(Cycle_count),     32'(exp_cc));
    endtask

    // One Go-initiated sequence from IDLE/DONE; d[i] is the RUN length client i needs.
    task automatic run_sequence(input logic [2:0] skip, input int d0, input int d1,
                                input int d2, input logic [2:0] idle_hi);
        int         d [3];
        int         s [3];
        int         g;
        int         e;
        int         nxt;
        logic [2:0] fm, fv, e_start;
        logic [1:0] e_own;
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        g    = cyc;
        nxt  = g + 1;
        for (int i = 0; i < 3; i++) begin
            s[i] = nxt;
            if (!skip[i]) nxt += d[i] + G + 1;
        end
        e    = nxt;
        Go   = 1'b1;
        Skip = skip;
        drive(idle_hi, idle_hi);
        for (int n = g + 1; n <= e; n++) begin
            tick();
            Go      = (n < e) ? 1'($urandom_range(0, 1)) : 1'b0;
            Skip    = 3'($urandom);
            fm      = idle_hi;
            fv      = idle_hi;
            e_start = 3'b000;
            e_own   = 2'd3;
            for (int i = 0; i < 3; i++) begin
                if (!skip[i]) begin
                    if (n > s[i] && n < s[i] + d[i]) begin
                        fm[i] = 1'b1;
                        fv[i] = 1'b0;
                    end
                    if (n == s[i] + d[i]) begin
                        fm[i] = 1'b1;
                        fv[i] = 1'b1;
                    end
                    if (n == s[i]) begin
                        e_start[i] = 1'b1;
                        e_own      = 2'(i);
                        exp_phase  = 2'(i);
                    end
                    if (n > s[i] && n <= s[i] + d[i]) e_own = 2'(i);
                    if (n == s[i] + d[i] + 1) exp_cc = 24'(d[i]);
                end
            end
            drive(fm, fv);
            check_cycle(e_start, e_own, n != e, n == e, 1'b0);
        end
    endtask

    initial begin
        int g;
        addr_c[0] = 18'h00010;
        addr_c[1] = 18'h09600;
        addr_c[2] = 18'h23E00;
        Reset     = 1'b1;
        Go        = 1'b0;
        Skip      = 3'b000;
        exp_phase = 2'd3;
        exp_cc    = 24'd0;
        drive(3'b000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(3'b000, 3'b000);
        end
        check_cycle(3'b000, 2'd3, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;

        // Full sequence, stops after 10/20/30 RUN cycles.
        run_sequence(3'b000, 10, 20, 30, 3'b000);
        // Only M1 enabled; LOAD and M2 Stop toggle randomly and must be ignored.
        run_sequence(3'b101, 10, 15, 10, 3'b000);
        // Everything skipped: Done on the cycle after Go.
        run_sequence(3'b111, 5, 5, 5, 3'b000);
        // M1 Stop held high from before its START.
        run_sequence(3'b000, 5, 1, 7, 3'b010);
        for (int r = 0; r < 5; r++) begin
            run_sequence(3'($urandom), $urandom_range(1, 40), $urandom_range(1, 40),
                         $urandom_range(1, 40), 3'b000);
        end

        // Reset in the middle of M2's RUN.
        g    = cyc;
        Skip = 3'b011;
        Go   = 1'b1;
        drive(3'b100, 3'b000);
        for (int n = g + 1; n <= g + 6; n++) begin
            tick();
            Go = 1'b0;
            drive(3'b100, 3'b000);
            we_v[2] = 1'b0;
            #1;
            if (n == g + 1) exp_phase = 2'd2;
            check_cycle((n == g + 1) ? 3'b100 : 3'b000, 2'd2, 1'b1, 1'b0, 1'b0);
        end
        Reset = 1'b1;
        tick();
        drive(3'b100, 3'b000);
        we_v[2] = 1'b0;
        #1;
        exp_phase = 2'd3;
        exp_cc    = 24'd0;
        check_cycle(3'b000, 2'd3, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        run_sequence(3'b000, 3, 4, 5, 3'b000);

        // M1 never stops: ERROR after TO RUN cycles.
        g    = cyc;
        Skip = 3'b101;
        Go   = 1'b1;
        drive(3'b010, 3'b000);
        for (int n = g + 1; n <= g + TO + 2; n++) begin
            tick();
            Go = 1'($urandom_range(0, 1));
            drive(3'b010, 3'b000);
            if (n == g + 1) exp_phase = 2'd1;
            if (n <= g + TO + 1) begin
                check_cycle((n == g + 1) ? 3'b010 : 3'b000, 2'd1, 1'b1, 1'b0, 1'b0);
            end else begin
                check_cycle(3'b000, 2'd3, 1'b0, 1'b0, 1'b1);
            end
        end
        for (int n = 0; n < 6; n++) begin
            Go   = 1'b1;
            Skip = 3'b000;
            tick();
            drive(3'b000, 3'b000);
            check_cycle(3'b000, 2'd3, 1'b0, 1'b0, 1'b1);
        end
        Go    = 1'b0;
        Reset = 1'b1;
        tick();
        drive(3'b000, 3'b000);
        exp_phase = 2'd3;
        exp_cc    = 24'd0;
        check_cycle(3'b000, 2'd3, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        run_sequence(3'b000, 2, 3, 4, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_phase_sequencer.md
Name: sram_phase_sequencer

Overview:
- Top-level controller that owns the single external SRAM port and runs the decoder phases in fixed order: LOAD (image loader), M1 (colour-space conversion / upsampling), M2 (IDCT).
- Issues a one-cycle Start to each enabled phase and waits for its Stop.
- Muxes the owning client's address, write-data and we_n onto the SRAM.
- Parks the bus for a guard interval between owners so that in-flight reads and writes never cross clients.

Parameters:
- GUARD_CYCLES, 3, parked-bus cycles after each Stop (covers 2-cycle SRAM read latency plus margin); must be 1..15.
- TIMEOUT, 24'd16000000, maximum RUN cycles per phase before ERROR.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Go  in  1  level; starts a sequence when sampled in IDLE or DONE
- Skip  in  3  bit0=LOAD, bit1=M1, bit2=M2; sampled on the Go cycle only
- LOAD_Start/M1_Start/M2_Start  out  1 each  one-cycle start pulse to each client
- LOAD_Stop/M1_Stop/M2_Stop  in  1 each  client completion level
- LOAD_address/M1_address/M2_address  in  18 each  client SRAM address
- LOAD_write_data/M1_write_data/M2_write_data  in  16 each  client write data
- LOAD_we_n/M1_we_n/M2_we_n  in  1 each  client write enable, active low
- SRAM_address  out  18  muxed address
- SRAM_write_data  out  16  muxed write data
- SRAM_we_n  out  1  muxed write enable
- Busy  out  1  high in any state other than IDLE, DONE, ERROR
- Done  out  1  high in DONE
- Error  out  1  high in ERROR
- Phase  out  2  current or last phase: 0=LOAD, 1=M1, 2=M2, 3=none
- Cycle_count  out  24  RUN-cycle count of the most recently completed phase

Behaviour:
- Reset:
  - State=IDLE, owner=none, Phase=3, all *_Start=0, Busy=Done=Error=0, Cycle_count=0.
  - Bus parked: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
  - Reset mid-phase aborts immediately; the client is not notified.
- States: IDLE, START, RUN, GUARD, DONE, ERROR. Phase index p in {0,1,2}.
- IDLE/DONE with Go=1:
  - Latch Skip.
  - p = lowest non-skipped phase, then go to START.
  - If all three are skipped, go directly to DONE.
  - Go is ignored in START, RUN, GUARD and ERROR.
- START (exactly 1 cycle):
  - The selected client's Start is 1 and all others are 0.
  - owner=p; the bus is now driven by client p.
  - Clear the run counter; go to RUN.
- RUN:
  - Run counter increments every cycle, saturating at 2^24-1.
  - Client p's Stop sampled 1 (from the first RUN cycle onward): Cycle_count <= counter value including this cycle, go to GUARD.
  - Counter reaches TIMEOUT without Stop: go to ERROR. Phase holds p, owner becomes none.
  - Stop takes priority over timeout when both occur in the same cycle.
  - Stops from non-owning clients are ignored in every state.
- Bus mux (combinational from the registered owner):
  - owner=p: SRAM_* = client p's signals.
  - owner=none (IDLE, GUARD, DONE, ERROR): parked values.
  - The mux adds no latency. Clients observe SRAM_read_data directly; it does not pass through this block.
- GUARD:
  - owner=none for exactly GUARD_CYCLES cycles.
  - Then the next non-skipped phase after p goes to START. If no phase remains, go to DONE with Phase=last run phase.
- DONE: sticky until Go (restarts the sequence) or Reset.
- ERROR: sticky, left only by Reset.
- Start pulses are registered outputs and never high for more than one consecutive cycle.
- A client holding Stop high at START time finishes on its first RUN cycle (Cycle_count=1). This is legal and not an error.

Test Plan:
- Skip=0, Go pulse; clients raise Stop 10, 20, 30 cycles after their Start. Required:
  - Start pulses in order LOAD, M1, M2, each one cycle.
  - M1_Start occurs exactly GUARD_CYCLES+1 cycles after LOAD_Stop is sampled.
  - Cycle_count=10, then 20, then 30.
  - Done=1 and Phase=2 at the end.
- During each RUN, drive distinct addresses (LOAD=18'h00010, M1=18'h09600, M2=18'h23E00) with we_n=0. Required:
  - SRAM_* matches only the owner.
  - During GUARD, SRAM_we_n=1 and SRAM_address=0 even while the clients keep we_n=0.
- Skip=3'b101, Go. Required: only M1_Start fires, and LOAD_Stop/M2_Stop pulses are ignored. Skip=3'b111 → Done on the cycle after Go, with no Start pulses.
- TIMEOUT=100, M1 never asserts Stop. Required: Error=1 after 100 RUN cycles, Phase=1, bus parked; a Go pulse leaves ERROR unchanged and Reset returns to IDLE.
- Assert Reset in the middle of M2's RUN with M2_we_n=0. Required: on the next edge SRAM_we_n=1, Busy=0, Phase=3; a later Go restarts at LOAD.
- M1_Stop held high from before START. Required: GUARD entered after a single RUN cycle with Cycle_count=1; Go pulses in RUN do not restart the sequence.
